// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin write-port arbiter for one sync FIFO. Each owner
//               keeps the port for a bounded burst. Flow control comes from a
//               local credit counter instead of the FIFO's lagging full flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_MAX  = 4,
  parameter int CNT_W      = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        fifo_write_enable,
  output logic [DATA_W-1:0]           fifo_data_in,
  input  logic                        fifo_pop,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [CNT_W-1:0]            credits,
  output logic                        credit_err
);

  localparam int                 c_ID_W  = $clog2(NUM_REQ);
  localparam int                 c_BC_W  = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0]   c_DEPTH = CNT_W'(FIFO_DEPTH);
  localparam logic [c_BC_W-1:0]  c_BURST = c_BC_W'(BURST_MAX);
  localparam logic [c_ID_W:0]    c_NUM   = (c_ID_W + 1)'(NUM_REQ);
  localparam logic [c_ID_W-1:0]  c_LAST  = c_ID_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_ID_W-1:0]   r_owner, w_owner_nxt;
  logic [c_ID_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [c_BC_W-1:0]   r_burst_cnt, w_burst_cnt_nxt;
  logic [CNT_W-1:0]    r_credits;
  logic                r_credit_err;
  logic                r_fifo_we;
  logic [DATA_W-1:0]   r_fifo_data;
  logic [c_ID_W-1:0]   r_grant_id;

  logic                w_rr_found;
  logic [c_ID_W-1:0]   w_rr_idx;
  logic                w_lock_cont;
  logic                w_grant;
  logic [c_ID_W-1:0]   w_grant_idx;
  logic [NUM_REQ-1:0]  w_ready;
  logic                w_pop_ovf;

  // Round-robin scan: first valid requester at or after rr_ptr (wrapping).
  // The loop runs from the far end so the nearest match is written last.
  always_comb begin
    logic [c_ID_W:0] v_sum;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    v_sum      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      v_sum = {1'b0, r_rr_ptr} + (c_ID_W + 1)'(i);
      if (v_sum >= c_NUM) begin
        v_sum = v_sum - c_NUM;
      end
      if (req_valid[v_sum[c_ID_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = v_sum[c_ID_W-1:0];
      end
    end
  end

  // Owner keeps the port while it is still valid and under the burst limit.
  assign w_lock_cont = (r_state == ST_LOCK) && req_valid[r_owner] &&
                       (r_burst_cnt < c_BURST);

  // Grant selection and next-state: lock continuation first, then RR.
  always_comb begin
    w_state_nxt     = ST_IDLE;
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = '0;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_grant         = 1'b0;
    w_grant_idx     = r_owner;
    if (r_credits != '0) begin
      if (w_lock_cont) begin
        w_grant         = 1'b1;
        w_grant_idx     = r_owner;
        w_burst_cnt_nxt = r_burst_cnt + c_BC_W'(1);
        w_state_nxt     = ST_LOCK;
      end else if (w_rr_found) begin
        w_grant         = 1'b1;
        w_grant_idx     = w_rr_idx;
        w_owner_nxt     = w_rr_idx;
        w_burst_cnt_nxt = c_BC_W'(1);
        w_state_nxt     = ST_LOCK;
        w_rr_ptr_nxt    = (w_rr_idx == c_LAST) ? '0 : w_rr_idx + c_ID_W'(1);
      end
    end
  end

  // One-hot ready; held low while reset is asserted.
  always_comb begin
    w_ready = '0;
    if (w_grant && rst_n) begin
      w_ready[w_grant_idx] = 1'b1;
    end
  end

  assign req_ready = w_ready;

  // A pop with every slot already free is a consumer protocol error.
  assign w_pop_ovf = fifo_pop && (r_credits == c_DEPTH);

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Registered FIFO write port and last-grant index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_we   <= 1'b0;
      r_fifo_data <= '0;
      r_grant_id  <= '0;
    end else begin
      r_fifo_we <= w_grant;
      if (w_grant) begin
        r_fifo_data <= req_data[w_grant_idx*DATA_W +: DATA_W];
        r_grant_id  <= w_grant_idx;
      end
    end
  end

  // Credit counter: a grant consumes a slot, a pop returns one; saturates at depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits    <= c_DEPTH;
      r_credit_err <= 1'b0;
    end else begin
      if (w_grant && !fifo_pop) begin
        r_credits <= r_credits - CNT_W'(1);
      end else if (!w_grant && fifo_pop && !w_pop_ovf) begin
        r_credits <= r_credits + CNT_W'(1);
      end
      if (w_pop_ovf) begin
        r_credit_err <= 1'b1;
      end
    end
  end

  assign fifo_write_enable = r_fifo_we;
  assign fifo_data_in      = r_fifo_data;
  assign grant_id          = r_grant_id;
  assign credits           = r_credits;
  assign credit_err        = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter. A reference model
//               tracks FIFO contents as a queue and derives credits from the
//               occupancy; arbitration is modelled from the round-robin and
//               burst rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int BURST_MAX  = 4;
  localparam int CNT_W      = 5;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       fifo_write_enable;
  logic [DATA_W-1:0]          fifo_data_in;
  logic                       fifo_pop;
  logic [1:0]                 grant_id;
  logic [CNT_W-1:0]           credits;
  logic                       credit_err;

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
    .BURST_MAX(BURST_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_write_enable(fifo_write_enable),
    .fifo_data_in(fifo_data_in), .fifo_pop(fifo_pop), .grant_id(grant_id),
    .credits(credits), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0] m_fifo[$];
  bit         m_inflight;
  logic [7:0] m_inflight_data;
  int         m_gid;
  bit         m_err;
  bit         m_locked;
  int         m_owner, m_streak, m_ptr;

  // Producer side
  logic [7:0] word [NUM_REQ];
  bit         seq_mode;
  int         obs_xfers;
  int         obs_g;
  int         glog[$];

  function automatic int m_credits();
    return FIFO_DEPTH - m_fifo.size() - int'(m_inflight);
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_inflight = 0; m_inflight_data = 8'h00; m_gid = 0; m_err = 0;
    m_locked = 0; m_owner = 0; m_streak = 0; m_ptr = 0;
  endtask

  task automatic check_regs();
    check_eq("credits", 32'(credits), 32'(m_credits()));
    check_eq("fifo_we", 32'(fifo_write_enable), 32'(m_inflight));
    if (m_inflight) check_eq("fifo_data", 32'(fifo_data_in), 32'(m_inflight_data));
    check_eq("grant_id", 32'(grant_id), 32'(m_gid));
    check_eq("credit_err", 32'(credit_err), 32'(m_err));
    check_eq("no_overflow", 32'(fifo_write_enable && (m_fifo.size() >= FIFO_DEPTH)), 32'd0);
  endtask

  // One cycle: drive at the negedge, check ready, advance model, check registers.
  task automatic step(input logic [NUM_REQ-1:0] v, input bit want_pop, input bit force_pop);
    int         g;
    bit         p;
    bit         ovf;
    logic [3:0] exp_ready;
    req_valid = v;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = word[i];
    p = force_pop || (want_pop && (m_fifo.size() > 0));
    fifo_pop = p;
    #1;
    g = -1;
    if (m_credits() != 0 && v != '0) begin
      if (m_locked && v[m_owner] && m_streak < BURST_MAX) begin
        g = m_owner;
        m_streak++;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (g < 0 && v[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
        end
        m_owner  = g;
        m_streak = 1;
        m_ptr    = (g + 1) % NUM_REQ;
        m_locked = 1;
      end
    end else begin
      m_locked = 0;
    end
    exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    obs_g = -1;
    for (int i = 0; i < NUM_REQ; i++) if (req_ready[i] && req_valid[i]) obs_g = i;
    if (obs_g >= 0) begin
      obs_xfers++;
      glog.push_back(obs_g);
    end
    ovf = p && (m_credits() == FIFO_DEPTH);
    if (m_inflight) m_fifo.push_back(m_inflight_data);
    if (p && !ovf && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (ovf) m_err = 1;
    m_inflight = (g >= 0);
    if (g >= 0) begin
      m_inflight_data = word[g];
      m_gid = g;
      word[g] = seq_mode ? word[g] + 8'd1 : 8'($urandom);
    end
    @(negedge clk);
    check_regs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    fifo_pop = 1'b0;
    model_reset();
    #1;
    check_regs();
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_order[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_pop = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) word[i] = 8'($urandom);
    seq_mode = 0; obs_xfers = 0; obs_g = -1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single producer streams 20 words into an empty FIFO, no pops
    seq_mode = 1; word[0] = 8'h00; obs_xfers = 0;
    repeat (20) step(4'b0001, 1'b0, 1'b0);
    check_eq("A_xfers", 32'(obs_xfers), 32'd16);
    check_eq("A_credits", 32'(credits), 32'd0);
    check_eq("A_ready_low", 32'(req_ready), 32'd0);
    repeat (20) step(4'b0000, 1'b1, 1'b0);
    check_eq("B_drained", 32'(credits), 32'd16);

    // All producers valid, consumer pops whenever data is present
    do_reset();
    seq_mode = 0; glog.delete();
    step(4'b1111, 1'b1, 1'b0);
    repeat (23) begin
      step(4'b1111, 1'b1, 1'b0);
      check_eq("C_we_high", 32'(fifo_write_enable), 32'd1);
    end
    for (int k = 0; k < 17; k++)
      check_eq("C_order", 32'((glog.size() > k) ? glog[k] : -1), 32'(exp_order[k]));

    // Producer 2 alone: burst restarts without bubbles
    repeat (16) begin
      step(4'b0100, 1'b1, 1'b0);
      check_eq("D_gid", 32'(grant_id), 32'd2);
      check_eq("D_we", 32'(fifo_write_enable), 32'd1);
    end
    repeat (20) step(4'b0000, 1'b1, 1'b0);

    // credits==0, then pop and valid together: no grant, then grant
    seq_mode = 0;
    repeat (17) step(4'b0001, 1'b0, 1'b0);
    check_eq("E_zero", 32'(credits), 32'd0);
    step(4'b0001, 1'b1, 1'b0);
    check_eq("E_nogrant", 32'(obs_g), 32'hFFFF_FFFF);
    check_eq("E_one", 32'(credits), 32'd1);
    step(4'b0001, 1'b0, 1'b0);
    check_eq("E_grant", 32'(obs_g), 32'd0);
    check_eq("E_back_zero", 32'(credits), 32'd0);
    repeat (20) step(4'b0000, 1'b1, 1'b0);

    // Owner 1 drops valid after two words while 3 waits
    do_reset();
    step(4'b1010, 1'b1, 1'b0);
    check_eq("F_g1a", 32'(obs_g), 32'd1);
    step(4'b1010, 1'b1, 1'b0);
    check_eq("F_g1b", 32'(obs_g), 32'd1);
    step(4'b1000, 1'b1, 1'b0);
    check_eq("F_g3", 32'(obs_g), 32'd3);
    step(4'b0101, 1'b1, 1'b0);
    check_eq("F_ptr0", 32'(obs_g), 32'd0);
    repeat (20) step(4'b0000, 1'b1, 1'b0);

    // Randomized traffic with varying consumer speed
    for (int chunk = 0; chunk < 8; chunk++) begin
      int ratio;
      ratio = $urandom_range(1, 9);
      repeat (200) step(4'($urandom), ($urandom % 10) < ratio, 1'b0);
    end
    repeat (40) step(4'b0000, 1'b1, 1'b0);
    check_eq("G_drained", 32'(credits), 32'd16);

    // Spurious pop at full credit, then asynchronous reset mid-burst
    step(4'b0000, 1'b0, 1'b1);
    check_eq("H_err", 32'(credit_err), 32'd1);
    check_eq("H_sat", 32'(credits), 32'd16);
    repeat (3) step(4'b0010, 1'b0, 1'b0);
    #2;
    req_valid = 4'b0010;
    rst_n = 1'b0;
    #1;
    check_eq("H_rst_we", 32'(fifo_write_enable), 32'd0);
    check_eq("H_rst_data", 32'(fifo_data_in), 32'd0);
    check_eq("H_rst_gid", 32'(grant_id), 32'd0);
    check_eq("H_rst_credits", 32'(credits), 32'd16);
    check_eq("H_rst_err", 32'(credit_err), 32'd0);
    check_eq("H_rst_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0001, 1'b0, 1'b0);
    check_eq("H_after", 32'(obs_g), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
